// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: next-PC selection,
// misaligned-target faults, eret, halt/resume and a retired-instruction counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic        fetch_valid,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic        halt_req,
    input  logic        resume,
    output logic        exc,
    output logic [31:0] epc,
    output logic [31:0] badaddr,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        fetch_valid_r;
    logic        exc_r;
    logic [31:0] epc_r;
    logic [31:0] badaddr_r;
    logic        halted_r;
    logic [31:0] retired_r;

    logic [31:0] target_s;
    logic        redirect_s;
    logic        fault_s;

    // Select the redirect target (jr > j > branch); falls back to pc_plus4 when none.
    always_comb begin
        target_s   = pc_plus4;
        redirect_s = 1'b0;
        if (jump_reg) begin
            target_s   = jr_target;
            redirect_s = 1'b1;
        end else if (jump) begin
            target_s   = jump_target;
            redirect_s = 1'b1;
        end else if (branch_taken) begin
            target_s   = branch_target;
            redirect_s = 1'b1;
        end else begin
            target_s   = pc_plus4;
            redirect_s = 1'b0;
        end
        fault_s = redirect_s && (target_s[1:0] != 2'b00);
    end

    // Sequencer state, PC and fault/retire bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            fetch_valid_r <= 1'b0;
            exc_r         <= 1'b0;
            epc_r         <= 32'h0000_0000;
            badaddr_r     <= 32'h0000_0000;
            halted_r      <= 1'b0;
            retired_r     <= 32'h0000_0000;
        end else begin
            exc_r <= 1'b0;
            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                    halted_r      <= 1'b0;
                end
                RUN: begin
                    if (stall) begin
                        pc_r <= pc_r;
                    end else if (halt_req) begin
                        // halt wins over any redirect; the halting instruction still retires
                        pc_r          <= pc_plus4;
                        state_r       <= HALT;
                        fetch_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                        retired_r     <= retired_r + 32'd1;
                    end else if (fault_s) begin
                        pc_r      <= EXC_VECTOR;
                        epc_r     <= pc_r;
                        badaddr_r <= target_s;
                        exc_r     <= 1'b1;
                    end else if (eret) begin
                        pc_r      <= epc_r;
                        retired_r <= retired_r + 32'd1;
                    end else begin
                        pc_r      <= target_s;
                        retired_r <= retired_r + 32'd1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        pc_r          <= pc_plus4;
                        state_r       <= RUN;
                        fetch_valid_r <= 1'b1;
                        halted_r      <= 1'b0;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    state_r       <= BOOT;
                    fetch_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign exc         = exc_r;
    assign epc         = epc_r;
    assign badaddr     = badaddr_r;
    assign halted      = halted_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        eret;
    logic        halt_req;
    logic        resume;
    logic        exc;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        halted;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid), .pc_plus4(pc_plus4),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg), .jr_target(jr_target),
        .eret(eret), .halt_req(halt_req), .resume(resume), .exc(exc), .epc(epc),
        .badaddr(badaddr), .halted(halted), .retired(retired)
    );

    // External incrementer
    assign pc_plus4 = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; jump_reg = 1'b0; jr_target = 32'h0;
        eret = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // T1: reset and plain sequencing
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_exc", {31'd0, exc}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_badaddr", badaddr, 32'h0);
        rst = 1'b0;
        step();
        chk("boot_pc", pc, 32'h0);
        chk("boot_fv", {31'd0, fetch_valid}, 32'd1);
        chk("boot_retired", retired, 32'd0);
        step(); chk("seq_pc4", pc, 32'h4);
        step(); chk("seq_pc8", pc, 32'h8);
        step(); chk("seq_pc12", pc, 32'hC);
        chk("seq_retired", retired, 32'd3);

        // T2: redirect priority
        branch_taken = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h100;
        step(); chk("j_over_br", pc, 32'h100);
        jump_reg = 1'b1; jr_target = 32'h200;
        step(); chk("jr_over_j", pc, 32'h200);
        chk("t2_retired", retired, 32'd5);
        clear_inputs();

        // T3: misaligned jr fault, then eret
        jump = 1'b1; jump_target = 32'h20;
        step(); chk("to_0x20", pc, 32'h20);
        clear_inputs();
        jump_reg = 1'b1; jr_target = 32'h1002;
        step();
        chk("fault_pc", pc, 32'h80);
        chk("fault_epc", epc, 32'h20);
        chk("fault_badaddr", badaddr, 32'h1002);
        chk("fault_exc", {31'd0, exc}, 32'd1);
        chk("fault_retired", retired, 32'd6);
        clear_inputs();
        step();
        chk("exc_pulse_end", {31'd0, exc}, 32'd0);
        chk("after_fault_pc", pc, 32'h84);
        eret = 1'b1;
        step();
        chk("eret_pc", pc, 32'h20);
        chk("eret_retired", retired, 32'd8);
        clear_inputs();

        // T4: stall freezes everything
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h60;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 32'h20);
            chk("stall_retired", retired, 32'd8);
            chk("stall_exc", {31'd0, exc}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("unstall_br", pc, 32'h60);
        chk("unstall_retired", retired, 32'd9);
        clear_inputs();

        // T5: halt (redirect dropped), hold, resume
        jump = 1'b1; jump_target = 32'h30;
        step(); chk("to_0x30", pc, 32'h30);
        jump_target = 32'h200; halt_req = 1'b1;
        step();
        chk("halt_pc", pc, 32'h34);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
        chk("halt_retired", retired, 32'd11);
        clear_inputs();
        branch_taken = 1'b1; branch_target = 32'h41; halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_pc", pc, 32'h34);
            chk("hold_halted", {31'd0, halted}, 32'd1);
            chk("hold_exc", {31'd0, exc}, 32'd0);
        end
        clear_inputs();
        resume = 1'b1;
        step();
        chk("resume_pc", pc, 32'h38);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_fv", {31'd0, fetch_valid}, 32'd1);
        chk("resume_retired", retired, 32'd11);
        clear_inputs();

        // PC wrap through the external incrementer
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step(); chk("to_top", pc, 32'hFFFF_FFFC);
        clear_inputs();
        step(); chk("pc_wrap", pc, 32'h0);
        chk("wrap_retired", retired, 32'd13);

        // T6: retired counter wrap
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        step();
        chk("retired_wrap", retired, 32'd0);
        chk("retired_wrap_pc", pc, 32'h4);

        // Misaligned branch fault
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        chk("br_fault_pc", pc, 32'h80);
        chk("br_fault_epc", epc, 32'h4);
        chk("br_fault_badaddr", badaddr, 32'h43);
        chk("br_fault_retired", retired, 32'd0);
        clear_inputs();

        // Reset mid-HALT
        halt_req = 1'b1;
        step();
        chk("halt2", {31'd0, halted}, 32'd1);
        clear_inputs();
        rst = 1'b1;
        step();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst2_retired", retired, 32'd0);
        chk("rst2_epc", epc, 32'h0);
        chk("rst2_badaddr", badaddr, 32'h0);
        chk("rst2_exc", {31'd0, exc}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst2_boot_fv", {31'd0, fetch_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
